vga_fb_arbiter: RTL and testbench

- Shares one single-port framebuffer RAM between the VGA scan-out path and a pixel writer (draw engine or CPU); also runs a hardware clear engine.
- Scan-out fetches use the display address pair (addrH/addrV, 640x480 space); each fetch is downscaled to a FB_W x FB_H framebuffer.
- Scan-out has absolute priority. Writer and clear use only the cycles scan-out leaves free, typically blanking.
- Sits between the VGA timing generator and the framebuffer BRAM, in the clk25 domain.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_fb_arbiter_if.sv | 56 +++++
 rtl/vga_fb_addr.sv | 33 +++
 rtl/vga_fb_arbiter.sv | 153 +++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared constants and enums for the VGA framebuffer arbiter slice.
package vga_pkg;

    // 640x480 display timing space
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned DISP_COORD_W = 10;

    localparam int unsigned DEF_FB_W        = 160;
    localparam int unsigned DEF_FB_H        = 120;
    localparam int unsigned DEF_SCALE_SHIFT = 2;
    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_ADDR_W      = 15;

    localparam int unsigned WR_X_W = 8;
    localparam int unsigned WR_Y_W = 7;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_DISP = 2'd1,
        SRC_CLR  = 2'd2,
        SRC_WR   = 2'd3
    } src_t;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Scan-out, writer, clear-control and RAM port signals of the framebuffer arbiter.
interface vga_fb_arbiter_if
    import vga_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
);
    logic                    disp_req;
    logic [DISP_COORD_W-1:0] disp_addrH;
    logic [DISP_COORD_W-1:0] disp_addrV;
    logic                    pix_valid;
    logic [DATA_W-1:0]       pix_data;

    logic                    wr_valid;
    logic                    wr_ready;
    logic [WR_X_W-1:0]       wr_x;
    logic [WR_Y_W-1:0]       wr_y;
    logic [DATA_W-1:0]       wr_data;

    logic                    clr_start;
    logic [DATA_W-1:0]       clr_color;
    logic                    clr_busy;
    logic                    clr_done;
    logic                    wr_oob;

    logic                    mem_en;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem_rdata;

    // arbiter side
    modport slave (
        input  disp_req, disp_addrH, disp_addrV,
        output pix_valid, pix_data,
        input  wr_valid, wr_x, wr_y, wr_data,
        output wr_ready,
        input  clr_start, clr_color,
        output clr_busy, clr_done, wr_oob,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // timing generator / writer / RAM side
    modport master (
        output disp_req, disp_addrH, disp_addrV,
        input  pix_valid, pix_data,
        output wr_valid, wr_x, wr_y, wr_data,
        input  wr_ready,
        output clr_start, clr_color,
        input  clr_busy, clr_done, wr_oob,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/vga_fb_addr.sv
// Combinational (x,y) to linear framebuffer address with downscale and range flag.
module vga_fb_addr #(
    parameter int unsigned X_W    = 10,
    parameter int unsigned Y_W    = 10,
    parameter int unsigned SHIFT  = 2,
    parameter int unsigned FB_W   = 160,
    parameter int unsigned FB_H   = 120,
    parameter int unsigned ADDR_W = 15
) (
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr,
    output logic              in_range
);

    logic [X_W-1:0] fx;
    logic [Y_W-1:0] fy;

    assign fx = x >> SHIFT;
    assign fy = y >> SHIFT;

    // 160 = 128 + 32, so the common width needs only two shifts and adds
    generate
        if (FB_W == 160) begin : g_shift_add
            assign addr = (ADDR_W'(fy) << 7) + (ADDR_W'(fy) << 5) + ADDR_W'(fx);
        end else begin : g_generic
            assign addr = ADDR_W'(ADDR_W'(fy) * ADDR_W'(FB_W)) + ADDR_W'(fx);
        end
    endgenerate

    assign in_range = (32'(fx) < FB_W) && (32'(fy) < FB_H);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scan-out fetch has priority, then the clear
// engine, then the pixel writer; one registered RAM slot per cycle.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned FB_W        = DEF_FB_W,
    parameter int unsigned FB_H        = DEF_FB_H,
    parameter int unsigned SCALE_SHIFT = DEF_SCALE_SHIFT,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned ADDR_W      = DEF_ADDR_W
) (
    input  logic            clk25,
    input  logic            rst,
    vga_fb_arbiter_if.slave bus
);

    localparam int unsigned       FB_SIZE   = FB_W * FB_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_SIZE - 1);

    logic [ADDR_W-1:0] disp_lin;
    logic              disp_in;
    logic [ADDR_W-1:0] wr_lin;
    logic              wr_in;

    state_t            state_q, state_d;
    src_t              src;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] color_q, color_d;
    logic              oob_set;
    logic              done_d;

    logic              fetch_v1, fetch_oob1, fetch_oob2;

    vga_fb_addr #(
        .X_W(DISP_COORD_W), .Y_W(DISP_COORD_W), .SHIFT(SCALE_SHIFT),
        .FB_W(FB_W), .FB_H(FB_H), .ADDR_W(ADDR_W)
    ) u_disp_addr (
        .x(bus.disp_addrH), .y(bus.disp_addrV), .addr(disp_lin), .in_range(disp_in)
    );

    vga_fb_addr #(
        .X_W(WR_X_W), .Y_W(WR_Y_W), .SHIFT(0),
        .FB_W(FB_W), .FB_H(FB_H), .ADDR_W(ADDR_W)
    ) u_wr_addr (
        .x(bus.wr_x), .y(bus.wr_y), .addr(wr_lin), .in_range(wr_in)
    );

    // Next state, slot arbitration and writer handshake
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        color_d      = color_q;
        src          = SRC_NONE;
        oob_set      = 1'b0;
        done_d       = 1'b0;
        bus.wr_ready = 1'b0;

        case (state_q)
            IDLE: begin
                bus.wr_ready = !bus.disp_req;
                if (bus.disp_req) begin
                    if (disp_in) src = SRC_DISP;
                end else if (bus.wr_valid) begin
                    if (wr_in) src = SRC_WR;
                    else       oob_set = 1'b1;
                end
                // a write in the same cycle still goes through; clearing starts next cycle
                if (bus.clr_start) begin
                    color_d = bus.clr_color;
                    cnt_d   = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                // a scan-out cycle stalls the counter rather than skipping an address
                if (bus.disp_req) begin
                    if (disp_in) src = SRC_DISP;
                end else begin
                    src   = SRC_CLR;
                    cnt_d = cnt_q + ADDR_W'(1);
                    if (cnt_q == LAST_ADDR) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and clear-engine registers
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            color_q      <= '0;
            bus.clr_busy <= 1'b0;
            bus.clr_done <= 1'b0;
            bus.wr_oob   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            color_q      <= color_d;
            bus.clr_busy <= (state_d == CLEAR);
            bus.clr_done <= done_d;
            bus.wr_oob   <= bus.wr_oob | oob_set;
        end
    end

    // RAM port; address and data hold on idle slots
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_en <= (src != SRC_NONE);
            bus.mem_we <= (src == SRC_CLR) || (src == SRC_WR);
            case (src)
                SRC_DISP: bus.mem_addr <= disp_lin;
                SRC_CLR: begin
                    bus.mem_addr  <= cnt_q;
                    bus.mem_wdata <= color_q;
                end
                SRC_WR: begin
                    bus.mem_addr  <= wr_lin;
                    bus.mem_wdata <= bus.wr_data;
                end
                default: ;
            endcase
        end
    end

    // Two-stage fetch tag pipeline matching the RAM read latency
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            fetch_v1      <= 1'b0;
            fetch_oob1    <= 1'b0;
            bus.pix_valid <= 1'b0;
            fetch_oob2    <= 1'b0;
        end else begin
            fetch_v1      <= bus.disp_req;
            fetch_oob1    <= bus.disp_req && !disp_in;
            bus.pix_valid <= fetch_v1;
            fetch_oob2    <= fetch_oob1;
        end
    end

    // RAM output register feeds the pixel directly; out-of-range fetches read as 0
    assign bus.pix_data = (bus.pix_valid && !fetch_oob2) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: a reference model predicts every RAM slot,
// pixel return and clr_done pulse; a negedge monitor compares them in order.
module tb_vga_fb_arbiter;

    localparam int FBW = 160;
    localparam int FBH = 120;
    localparam int LAST = FBW * FBH - 1;

    typedef struct {
        int cyc;
        bit we;
        int addr;
        int data;
    } mem_exp_t;

    typedef struct {
        int cyc;
        int data;
    } pix_exp_t;

    logic clk25;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_err;
    int   n_done;

    mem_exp_t mq[$];
    pix_exp_t pq[$];

    logic [7:0] ram    [0:32767];
    logic [7:0] shadow [0:32767];
    bit         ram_init_done;

    bit m_clear;
    bit m_oob;
    int m_cnt;
    int m_color;
    int exp_done_cyc;

    vga_fb_arbiter_if #(.DATA_W(8), .ADDR_W(15)) bus ();

    vga_fb_arbiter dut (
        .clk25(clk25),
        .rst  (rst),
        .bus  (bus)
    );

    initial clk25 = 1'b0;
    always #10 clk25 = ~clk25;

    always @(posedge clk25) cyc <= cyc + 1;

    // RAM model: one-cycle registered read
    always @(posedge clk25) begin
        if (!ram_init_done) begin
            for (int i = 0; i < 32768; i++) ram[i] <= 8'(i * 7 + 3);
            ram[162] <= 8'hA5;
            ram_init_done <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: every RAM slot, pixel return and clr_done pulse must match the model
    mem_exp_t me;
    pix_exp_t pe;
    bit       exp_act;
    always @(negedge clk25) begin
        if (!rst) begin
            exp_act = (mq.size() != 0) && (mq[0].cyc == cyc);
            if (bus.mem_en || exp_act) begin
                check("mem_en", int'(bus.mem_en), int'(exp_act));
                if (exp_act) begin
                    me = mq.pop_front();
                    if (bus.mem_en) begin
                        check("mem_we", int'(bus.mem_we), int'(me.we));
                        check("mem_addr", int'(bus.mem_addr), me.addr);
                        if (me.we) check("mem_wdata", int'(bus.mem_wdata), me.data);
                    end
                end
            end
            exp_act = (pq.size() != 0) && (pq[0].cyc == cyc);
            if (bus.pix_valid || exp_act) begin
                check("pix_valid", int'(bus.pix_valid), int'(exp_act));
                if (exp_act) begin
                    pe = pq.pop_front();
                    if (bus.pix_valid) check("pix_data", int'(bus.pix_data), pe.data);
                end
            end
            if (bus.clr_done || cyc == exp_done_cyc) begin
                check("clr_done", int'(bus.clr_done), int'(cyc == exp_done_cyc));
                if (bus.clr_done) n_done++;
            end
        end
    end

    // One stimulus cycle: drive, check combinational/status outputs, push predictions
    task automatic drive(input bit dreq, input int h, input int v, input bit wv,
                         input int x, input int y, input int d, input bit cs, input int cc);
        int fx, fy, a;
        bit exp_rdy;
        bus.disp_req   = dreq;
        bus.disp_addrH = 10'(h);
        bus.disp_addrV = 10'(v);
        bus.wr_valid   = wv;
        bus.wr_x       = 8'(x);
        bus.wr_y       = 7'(y);
        bus.wr_data    = 8'(d);
        bus.clr_start  = cs;
        bus.clr_color  = 8'(cc);
        #2;
        exp_rdy = !m_clear && !dreq;
        check("wr_ready", int'(bus.wr_ready), int'(exp_rdy));
        check("clr_busy", int'(bus.clr_busy), int'(m_clear));
        check("wr_oob", int'(bus.wr_oob), int'(m_oob));
        if (dreq) begin
            fx = h >> 2;
            fy = v >> 2;
            if (fx < FBW && fy < FBH) begin
                a = fy * FBW + fx;
                mq.push_back('{cyc + 1, 1'b0, a, 0});
                pq.push_back('{cyc + 2, int'(shadow[a])});
            end else begin
                pq.push_back('{cyc + 2, 0});
            end
        end
        if (m_clear) begin
            if (!dreq) begin
                mq.push_back('{cyc + 1, 1'b1, m_cnt, m_color});
                shadow[m_cnt] = 8'(m_color);
                if (m_cnt == LAST) begin
                    exp_done_cyc = cyc + 1;
                    m_clear = 1'b0;
                end
                m_cnt++;
            end
        end else begin
            if (wv && !dreq) begin
                if (x < FBW && y < FBH) begin
                    a = y * FBW + x;
                    mq.push_back('{cyc + 1, 1'b1, a, d});
                    shadow[a] = 8'(d);
                end else begin
                    m_oob = 1'b1;
                end
            end
            if (cs) begin
                m_clear = 1'b1;
                m_cnt   = 0;
                m_color = cc;
            end
        end
        @(posedge clk25);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        bus.disp_req = 1'b0; bus.disp_addrH = '0; bus.disp_addrV = '0;
        bus.wr_valid = 1'b0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_data = '0;
        bus.clr_start = 1'b0; bus.clr_color = '0;
        mq.delete();
        pq.delete();
        m_clear = 1'b0;
        m_oob = 1'b0;
        m_cnt = 0;
        exp_done_cyc = -1;
        #2;
        check("rst_mem_en", int'(bus.mem_en), 0);
        check("rst_mem_we", int'(bus.mem_we), 0);
        check("rst_mem_addr", int'(bus.mem_addr), 0);
        check("rst_mem_wdata", int'(bus.mem_wdata), 0);
        check("rst_pix_valid", int'(bus.pix_valid), 0);
        check("rst_pix_data", int'(bus.pix_data), 0);
        check("rst_clr_busy", int'(bus.clr_busy), 0);
        check("rst_clr_done", int'(bus.clr_done), 0);
        check("rst_wr_oob", int'(bus.wr_oob), 0);
        check("rst_wr_ready", int'(bus.wr_ready), 1);
        repeat (ncyc) @(posedge clk25);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int n;
        bit dr;
        cyc = 0; n_cmp = 0; n_err = 0; n_done = 0;
        ram_init_done = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 32768; i++) shadow[i] = 8'(i * 7 + 3);
        shadow[162] = 8'hA5;

        do_reset(3);
        idle(2);

        // scan-out read at display (8,4) -> fb (2,1)
        drive(1, 8, 4, 0, 0, 0, 0, 0, 0);
        check("rd_en", int'(bus.mem_en), 1);
        check("rd_we", int'(bus.mem_we), 0);
        check("rd_addr", int'(bus.mem_addr), 162);
        idle(1);
        check("rd_pix_valid", int'(bus.pix_valid), 1);
        check("rd_pix_data", int'(bus.pix_data), 8'hA5);

        // write in blanking to the last pixel
        drive(0, 0, 0, 1, 159, 119, 8'h3C, 0, 0);
        check("wr_we", int'(bus.mem_we), 1);
        check("wr_addr", int'(bus.mem_addr), 19199);
        check("wr_wdata", int'(bus.mem_wdata), 8'h3C);

        // conflict: scan-out holds the slot for 3 cycles, write lands on the 4th
        for (int i = 0; i < 3; i++) drive(1, 4 * i, 8, 1, 10, 10, 8'h55, 0, 0);
        drive(0, 0, 0, 1, 10, 10, 8'h55, 0, 0);
        check("cf_we", int'(bus.mem_we), 1);
        check("cf_addr", int'(bus.mem_addr), 1610);
        idle(1);

        // read back, display corner, out-of-range fetch
        drive(1, 40, 40, 0, 0, 0, 0, 0, 0);
        drive(1, 639, 479, 0, 0, 0, 0, 0, 0);
        check("edge_addr", int'(bus.mem_addr), 19199);
        drive(1, 640, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // out-of-range writes set the sticky flag
        drive(0, 0, 0, 1, 160, 0, 8'h99, 0, 0);
        idle(1);
        check("oob_flag", int'(bus.wr_oob), 1);
        drive(0, 0, 0, 1, 0, 120, 8'h98, 0, 0);
        idle(2);

        // random mixed traffic
        for (int i = 0; i < 300; i++)
            drive($urandom % 2 == 1, $urandom_range(0, 700), $urandom_range(0, 520),
                  $urandom % 2 == 1, $urandom_range(0, 165), $urandom_range(0, 123),
                  $urandom_range(0, 255), 0, 0);
        idle(2);

        // clear to 0x00 started together with a write, under 50% scan-out traffic
        drive(0, 0, 0, 1, 5, 5, 8'h11, 1, 8'h00);
        n = 0;
        while (m_clear && n < 60000) begin
            dr = ($urandom % 2 == 1);
            drive(dr, $urandom_range(0, 660), $urandom_range(0, 490),
                  $urandom % 2 == 1, $urandom_range(0, 159), $urandom_range(0, 119),
                  $urandom_range(0, 255), ($urandom % 8 == 0), 8'hEE);
            n++;
        end
        idle(3);
        check("clr_done_count", n_done, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 639, 479, 0, 0, 0, 0, 0, 0);
        drive(1, 320, 240, 0, 0, 0, 0, 0, 0);
        idle(3);

        // second clear abandoned by reset: no clr_done afterwards
        drive(0, 0, 0, 0, 0, 0, 0, 1, 8'h77);
        for (int i = 0; i < 100; i++) drive($urandom % 2 == 1, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset(2);
        idle(8);
        check("clr_done_after_rst", n_done, 1);

        check("mem_queue_left", mq.size(), 0);
        check("pix_queue_left", pq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
